// File: rtl/anu_mem_arbiter_if.sv
// Bundle between the memory arbiter, the core's fetch/data ports and the shared memory.
// master: the arbiter side. slave: the core and memory side.
interface anu_mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_access_mode;
    logic [31:0] d_rdata;
    logic        d_valid;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_access_mode;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    logic        stall;
    logic        err;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_access_mode,
               mem_rdata, mem_ack,
        output if_rdata, if_valid, d_rdata, d_valid,
               mem_req, mem_we, mem_addr, mem_wdata, mem_access_mode,
               stall, err
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_access_mode,
               mem_rdata, mem_ack,
        input  if_rdata, if_valid, d_rdata, d_valid,
               mem_req, mem_we, mem_addr, mem_wdata, mem_access_mode,
               stall, err
    );
endinterface

// File: rtl/anu_mem_arbiter.sv
// Round-robin arbiter of fetch and data ports onto one memory; one access in flight.
// Grant-to-valid 2 cycles minimum; requesters stall until valid, TIMEOUT aborts a dead access.
module anu_mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    anu_mem_arbiter_if.master bus
);
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_D  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        last_d;
    logic [7:0]  wait_cnt;
    logic [7:0]  wait_inc;
    logic        if_pend;
    logic        d_pend;
    logic        grant_if;
    logic        grant_d;
    logic        done;
    logic        abort;
    logic        fin_if;
    logic        fin_d;

    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [1:0]  mem_mode_q;
    logic [31:0] if_rdata_q;
    logic [31:0] d_rdata_q;
    logic        if_valid_q;
    logic        d_valid_q;
    logic        err_q;

    // A port showing valid this cycle is still holding req; masking it stops a re-grant.
    assign if_pend  = bus.if_req & ~if_valid_q;
    assign d_pend   = bus.d_req & ~d_valid_q;
    assign wait_inc = wait_cnt + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_d   = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (d_pend && (!last_d || !if_pend)) begin
                    state_nxt = GNT_D;
                    grant_d   = 1'b1;
                end else if (if_pend) begin
                    state_nxt = GNT_IF;
                    grant_if  = 1'b1;
                end
            end
            GNT_IF, GNT_D: begin
                // An ack landing on the final wait cycle still wins over the timeout.
                if (bus.mem_ack) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (wait_inc == TIMEOUT_CNT) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign fin_if = (done | abort) & (state == GNT_IF);
    assign fin_d  = (done | abort) & (state == GNT_D);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_mode_q  <= 2'b00;
            if_rdata_q  <= 32'd0;
            d_rdata_q   <= 32'd0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            err_q       <= 1'b0;
            last_d      <= 1'b0;
            wait_cnt    <= 8'd0;
        end else begin
            if_valid_q <= fin_if;
            d_valid_q  <= fin_d;
            if (grant_d) begin
                mem_req_q   <= 1'b1;
                mem_we_q    <= bus.d_we;
                mem_addr_q  <= bus.d_addr;
                mem_wdata_q <= bus.d_wdata;
                mem_mode_q  <= bus.d_access_mode;
                last_d      <= 1'b1;
                wait_cnt    <= 8'd0;
            end else if (grant_if) begin
                mem_req_q   <= 1'b1;
                mem_we_q    <= 1'b0;
                mem_addr_q  <= bus.if_addr;
                mem_wdata_q <= 32'd0;
                mem_mode_q  <= 2'b10;
                last_d      <= 1'b0;
                wait_cnt    <= 8'd0;
            end else if (done || abort) begin
                mem_req_q <= 1'b0;
            end else if (state != IDLE) begin
                wait_cnt <= wait_inc;
            end
            if (fin_if) begin
                if_rdata_q <= done ? bus.mem_rdata : 32'd0;
            end
            if (fin_d) begin
                d_rdata_q <= done ? bus.mem_rdata : 32'd0;
            end
            if (abort) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.mem_req         = mem_req_q;
    assign bus.mem_we          = mem_we_q;
    assign bus.mem_addr        = mem_addr_q;
    assign bus.mem_wdata       = mem_wdata_q;
    assign bus.mem_access_mode = mem_mode_q;
    assign bus.if_rdata        = if_rdata_q;
    assign bus.d_rdata         = d_rdata_q;
    assign bus.if_valid        = if_valid_q;
    assign bus.d_valid         = d_valid_q;
    assign bus.err             = err_q;
    assign bus.stall           = if_pend | d_pend;
endmodule

// File: tb/tb_anu_mem_arbiter.sv
// Bench for anu_mem_arbiter: directed scenarios then random traffic against a
// transaction-level model of grant order, memory response timing and timeouts.
module tb_anu_mem_arbiter;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    anu_mem_arbiter_if bus();

    anu_mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Model state: one access in flight, who owns it, when memory answers.
    bit          busy, exp_start, win_d, last_d, exp_ifv, exp_dv, exp_err;
    bit          just_if, just_d, rand_arr, use_frd;
    logic [31:0] exp_if_rd, exp_d_rd, frd;
    logic [31:0] g_addr, g_wdata;
    logic        g_we;
    logic [1:0]  g_mode;
    int          cyc, k, force_k, spur_mode, if_done, d_done;
    logic [31:0] grant_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        busy = 0; exp_start = 0; win_d = 0; last_d = 0; exp_ifv = 0; exp_dv = 0;
        exp_err = 0; just_if = 0; just_d = 0; exp_if_rd = 32'd0; exp_d_rd = 32'd0;
        cyc = 0; k = 0; if_done = 0; d_done = 0;
        grant_log.delete();
    endtask

    task automatic clear_inputs();
        bus.if_req = 1'b0; bus.if_addr = 32'd0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'd0; bus.d_wdata = 32'd0;
        bus.d_access_mode = 2'b00; bus.mem_rdata = 32'd0; bus.mem_ack = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_mem_mode", 32'(bus.mem_access_mode), 32'd0);
        chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_d_valid", 32'(bus.d_valid), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_if_rdata", bus.if_rdata, 32'd0);
        chk("rst_d_rdata", bus.d_rdata, 32'd0);
        rst_n = 1'b1;
    endtask

    // One clock: drive this cycle's inputs, predict, advance, then check what the DUT shows.
    task automatic step();
        bit was_busy;
        bit ack;
        if (rand_arr) begin
            if (!bus.if_req && !just_if && $urandom_range(2) == 0) begin
                bus.if_req  = 1'b1;
                bus.if_addr = $urandom() & 32'hFFFF_FFFC;
            end
            if (!bus.d_req && !just_d && $urandom_range(2) == 0) begin
                bus.d_req         = 1'b1;
                bus.d_we          = 1'($urandom_range(1));
                bus.d_addr        = $urandom();
                bus.d_wdata       = $urandom();
                bus.d_access_mode = 2'($urandom_range(2));
            end
        end
        just_if = 0;
        just_d  = 0;
        bus.mem_rdata = use_frd ? frd : $urandom();
        ack = 0;
        was_busy = busy;
        if (busy) begin
            ack = (cyc == k);
            if (ack || (cyc + 1 == TO)) begin
                busy = 0;
                if (!ack) exp_err = 1;
                if (win_d) begin
                    exp_dv = 1;
                    exp_d_rd = ack ? bus.mem_rdata : 32'd0;
                end else begin
                    exp_ifv = 1;
                    exp_if_rd = ack ? bus.mem_rdata : 32'd0;
                end
            end
            cyc++;
        end else begin
            ack = (spur_mode == 1) || (spur_mode == 2 && $urandom_range(1) == 1);
        end
        bus.mem_ack = ack;
        if (!was_busy) begin
            if (bus.d_req && (!last_d || !bus.if_req)) begin
                win_d = 1; last_d = 1; exp_start = 1;
                g_addr = bus.d_addr; g_we = bus.d_we; g_wdata = bus.d_wdata; g_mode = bus.d_access_mode;
            end else if (bus.if_req) begin
                win_d = 0; last_d = 0; exp_start = 1;
                g_addr = bus.if_addr; g_we = 1'b0; g_wdata = 32'd0; g_mode = 2'b10;
            end
        end
        @(posedge clk);
        #1;
        chk("if_valid", 32'(bus.if_valid), 32'(exp_ifv));
        chk("d_valid", 32'(bus.d_valid), 32'(exp_dv));
        chk("err", 32'(bus.err), 32'(exp_err));
        chk("if_rdata", bus.if_rdata, exp_if_rd);
        chk("d_rdata", bus.d_rdata, exp_d_rd);
        chk("stall", 32'(bus.stall), 32'((bus.if_req & ~exp_ifv) | (bus.d_req & ~exp_dv)));
        if (exp_ifv) begin bus.if_req = 1'b0; just_if = 1; if_done++; end
        if (exp_dv) begin bus.d_req = 1'b0; just_d = 1; d_done++; end
        exp_ifv = 0;
        exp_dv = 0;
        if (exp_start) begin
            exp_start = 0; busy = 1; cyc = 0;
            k = (force_k >= 0) ? force_k : $urandom_range(5);
            grant_log.push_back(g_addr);
        end
        if (busy) begin
            chk("mem_req_busy", 32'(bus.mem_req), 32'd1);
            chk("mem_addr", bus.mem_addr, g_addr);
            chk("mem_we", 32'(bus.mem_we), 32'(g_we));
            chk("mem_mode", 32'(bus.mem_access_mode), 32'(g_mode));
            if (win_d) chk("mem_wdata", bus.mem_wdata, g_wdata);
        end else begin
            chk("mem_req_idle", 32'(bus.mem_req), 32'd0);
        end
    endtask

    initial begin
        rand_arr = 0; use_frd = 0; frd = 32'd0; force_k = -1; spur_mode = 0;
        clear_inputs();
        model_reset();

        // Fetch only, memory answers one cycle after request.
        apply_reset();
        force_k = 1; use_frd = 1; frd = 32'h0010_0093;
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0004;
        repeat (6) step();
        chk("fetch_rdata", bus.if_rdata, 32'h0010_0093);
        chk("fetch_count", 32'(if_done), 32'd1);
        chk("fetch_addr", grant_log[0], 32'h0000_0004);
        chk("fetch_stall", 32'(bus.stall), 32'd0);

        // Contention after reset: data first, then fetch.
        apply_reset();
        force_k = 0; use_frd = 0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0100; bus.d_access_mode = 2'b10;
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0008;
        repeat (10) step();
        chk("cont_grants", 32'(grant_log.size()), 32'd2);
        chk("cont_first", grant_log[0], 32'h0000_0100);
        chk("cont_second", grant_log[1], 32'h0000_0008);
        chk("cont_done", 32'(if_done + d_done), 32'd2);

        // Store.
        apply_reset();
        force_k = 2;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_0200;
        bus.d_wdata = 32'hDEAD_BEEF; bus.d_access_mode = 2'b00;
        repeat (8) step();
        chk("store_count", 32'(d_done), 32'd1);
        chk("store_addr", grant_log[0], 32'h0000_0200);

        // Spurious acks while idle.
        apply_reset();
        spur_mode = 1;
        repeat (5) step();
        chk("spur_done", 32'(if_done + d_done), 32'd0);
        spur_mode = 0;

        // Good fetch, then one that memory never answers.
        apply_reset();
        force_k = 0; use_frd = 1; frd = 32'hCAFE_F00D;
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0010;
        repeat (5) step();
        force_k = 100; use_frd = 0;
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0040;
        repeat (10) step();
        chk("to_err", 32'(bus.err), 32'd1);
        chk("to_rdata", bus.if_rdata, 32'd0);
        chk("to_count", 32'(if_done), 32'd2);
        repeat (3) step();

        // Reset during a data access.
        apply_reset();
        force_k = 100;
        bus.d_req = 1'b1; bus.d_addr = 32'h0000_0300; bus.d_we = 1'b0; bus.d_access_mode = 2'b01;
        repeat (2) step();
        chk("rmid_in_gnt", 32'(bus.mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rmid_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rmid_err", 32'(bus.err), 32'd0);
        chk("rmid_addr", bus.mem_addr, 32'd0);
        clear_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        repeat (8) step();
        chk("rmid_no_valid", 32'(d_done), 32'd0);

        // Random traffic, random memory latency including timeouts and late acks.
        apply_reset();
        force_k = -1; use_frd = 0; spur_mode = 2; rand_arr = 1;
        repeat (400) step();
        rand_arr = 0;
        repeat (30) step();
        chk("rand_drained", 32'(bus.if_req | bus.d_req), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
